// File: rtl/mirror_pkg.sv
// Constants and FSM encoding shared by the mirror display SPI master and its
// slave receiver.
package mirror_pkg;

  localparam int MIRROR_COLS = 40;
  localparam int MIRROR_ROWS = 15;
  localparam int COL_W       = 6;
  localparam int ROW_W       = 4;
  localparam int STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_NEXT  = 3'd5,
    ST_HOLD  = 3'd6,
    ST_DONE  = 3'd7
  } fsm_state_t;

endpackage

// File: rtl/mirror_spi_master_if.sv
// Host, frame-store and SPI pins of the mirror SPI master, bundled as one
// interface.
interface mirror_spi_master_if;
  import mirror_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [7:0]       rd_data;
  logic             s_clk;
  logic             ss_n;
  logic             mosi;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_col, rd_row, s_clk, ss_n, mosi
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_col, rd_row, s_clk, ss_n, mosi
  );

endinterface

// File: rtl/mirror_spi_master_shifter.sv
// Serialises one byte MSB first in SPI mode 0; each bit is HALF_DIV clk low
// followed by HALF_DIV clk high.
module spi_byte_shifter #(
  parameter int HALF_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_s_clk,
  output logic       o_mosi,
  output logic       o_byte_done
);

  localparam logic [7:0] HD_LAST = 8'(HALF_DIV - 1);

  logic [7:0] r_shreg;
  logic [2:0] r_bit;
  logic [7:0] r_div;
  logic       r_active;
  logic       r_s_clk;
  logic       w_half_end;

  assign w_half_end  = r_active && (r_div == HD_LAST);
  // Final cycle of bit 0's high phase: lets the frame FSM leave SHIFT on the same edge.
  assign o_byte_done = w_half_end && r_s_clk && (r_bit == 3'd0);
  assign o_s_clk     = r_s_clk;
  assign o_mosi      = r_shreg[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg  <= 8'd0;
      r_bit    <= 3'd0;
      r_div    <= 8'd0;
      r_active <= 1'b0;
      r_s_clk  <= 1'b0;
    end else if (i_load) begin
      r_shreg  <= i_data;
      r_bit    <= 3'd7;
      r_div    <= 8'd0;
      r_active <= 1'b1;
      r_s_clk  <= 1'b0;
    end else if (r_active) begin
      if (w_half_end) begin
        r_div <= 8'd0;
        if (!r_s_clk) begin
          r_s_clk <= 1'b1;
        end else begin
          r_s_clk <= 1'b0;
          if (r_bit == 3'd0) begin
            r_active <= 1'b0;
          end else begin
            r_bit   <= r_bit - 3'd1;
            r_shreg <= {r_shreg[6:0], 1'b0};
          end
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mirror_spi_master.sv
// Streams a full COLS x ROWS character frame from the frame store to the
// mirror display receiver over SPI, with ss_n held low for the whole frame.
module mirror_spi_master
  import mirror_pkg::*;
#(
  parameter int COLS     = MIRROR_COLS,
  parameter int ROWS     = MIRROR_ROWS,
  parameter int HALF_DIV = 4,
  parameter int GUARD    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mirror_spi_master_if.master bus
);

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [7:0]       GUARD_LAST = 8'(GUARD - 1);

  fsm_state_t       r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [7:0]       r_guard_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic             r_ss_n;
  logic             w_load;
  logic             w_byte_done;

  assign w_load     = (r_state == ST_LOAD);
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.rd_en  = r_rd_en;
  assign bus.rd_col = r_col;
  assign bus.rd_row = r_row;
  assign bus.ss_n   = r_ss_n;

  spi_byte_shifter #(
    .HALF_DIV(HALF_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_data     (bus.rd_data),
    .o_s_clk    (bus.s_clk),
    .o_mosi     (bus.mosi),
    .o_byte_done(w_byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_guard_cnt <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_ss_n      <= 1'b1;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_SETUP;
            r_col       <= '0;
            r_row       <= '0;
            r_guard_cnt <= 8'd0;
            r_ss_n      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (r_guard_cnt == GUARD_LAST) begin
            r_state <= ST_FETCH;
            r_rd_en <= 1'b1;
          end else begin
            r_guard_cnt <= r_guard_cnt + 8'd1;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD:  r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_byte_done) r_state <= ST_NEXT;
        end
        // Column advances fastest, matching the receiver's fill order.
        ST_NEXT: begin
          if (r_col < COL_LAST) begin
            r_col   <= r_col + COL_W'(1);
            r_state <= ST_FETCH;
            r_rd_en <= 1'b1;
          end else begin
            r_col <= '0;
            if (r_row < ROW_LAST) begin
              r_row   <= r_row + ROW_W'(1);
              r_state <= ST_FETCH;
              r_rd_en <= 1'b1;
            end else begin
              r_state     <= ST_HOLD;
              r_guard_cnt <= 8'd0;
            end
          end
        end
        ST_HOLD: begin
          if (r_guard_cnt == GUARD_LAST) begin
            r_ss_n  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_guard_cnt <= r_guard_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mirror_spi_master.sv
// Bench for mirror_spi_master: a small 2x1 instance for framing/latency and a
// default 40x15 instance for the full frame, mid-frame reset and timing rules.
module tb_mirror_spi_master;
  import mirror_pkg::*;

  localparam int A_COLS = 2;
  localparam int A_ROWS = 1;
  localparam int A_HD   = 1;
  localparam int A_G    = 4;
  localparam int B_HD   = 4;
  localparam int B_G    = 4;
  localparam int B_N    = MIRROR_COLS * MIRROR_ROWS;
  localparam int A_LAT  = 1 + 2*A_G + A_COLS*A_ROWS*(16*A_HD + 3);
  localparam int B_LAT  = 1 + 2*B_G + B_N*(16*B_HD + 3);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  mirror_spi_master_if bus_a ();
  mirror_spi_master_if bus_b ();

  mirror_spi_master #(.COLS(A_COLS), .ROWS(A_ROWS), .HALF_DIV(A_HD), .GUARD(A_G)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mirror_spi_master #(.COLS(MIRROR_COLS), .ROWS(MIRROR_ROWS), .HALF_DIV(B_HD), .GUARD(B_G)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame stores: registered read, data valid only the cycle after rd_en.
  logic [7:0] mem_a [2];
  always @(posedge clk) bus_a.rd_data <= bus_a.rd_en ? mem_a[bus_a.rd_col[0]] : 8'hEE;
  always @(posedge clk)
    bus_b.rd_data <= bus_b.rd_en ? 8'(int'(bus_b.rd_row)*MIRROR_COLS + int'(bus_b.rd_col)) : 8'hEE;

  logic [7:0] exp_q_a[$], exp_q_b[$];
  logic [9:0] addr_q_a[$], addr_q_b[$];
  logic [7:0] rx_a = 8'd0, rx_b = 8'd0;
  logic [7:0] rx_log_b [B_N];
  logic [8:0] e_byte_a, e_byte_b;
  logic [10:0] e_addr_a, e_addr_b;
  int edges_a = 0, bits_a = 0, nrx_a = 0, ssviol_a = 0, tviol_a = 0, since_a = 0;
  int edges_b = 0, bits_b = 0, nrx_b = 0, ssviol_b = 0, tviol_b = 0, since_b = 0;
  int dcnt_b = 0, ssrise_b = 0;
  logic mosi_prev_a = 1'b0, sclk_prev_a = 1'b0, mosi_prev_b = 1'b0, sclk_prev_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI slave models: sample mosi on rising s_clk, compare each byte with the scoreboard.
  always @(posedge bus_a.s_clk) begin
    edges_a++;
    if (bus_a.ss_n !== 1'b0) ssviol_a++;
    rx_a = {rx_a[6:0], bus_a.mosi};
    bits_a++;
    if (bits_a == 8) begin
      bits_a = 0;
      if (exp_q_a.size() != 0) e_byte_a = {1'b0, exp_q_a.pop_front()};
      else e_byte_a = 9'h1FF;
      check("a_rx_byte", {23'd0, 1'b0, rx_a}, {23'd0, e_byte_a});
      nrx_a++;
    end
  end

  always @(posedge bus_b.s_clk) begin
    edges_b++;
    if (bus_b.ss_n !== 1'b0) ssviol_b++;
    rx_b = {rx_b[6:0], bus_b.mosi};
    bits_b++;
    if (bits_b == 8) begin
      bits_b = 0;
      if (nrx_b < B_N) rx_log_b[nrx_b] = rx_b;
      if (exp_q_b.size() != 0) e_byte_b = {1'b0, exp_q_b.pop_front()};
      else e_byte_b = 9'h1FF;
      check("b_rx_byte", {23'd0, 1'b0, rx_b}, {23'd0, e_byte_b});
      nrx_b++;
    end
  end

  // Read-address scoreboards and mosi/s_clk timing monitors.
  always @(negedge clk) begin
    if (rst_n && bus_a.rd_en === 1'b1) begin
      if (addr_q_a.size() != 0) e_addr_a = {1'b0, addr_q_a.pop_front()};
      else e_addr_a = 11'h7FF;
      check("a_rd_addr", {21'd0, 1'b0, bus_a.rd_row, bus_a.rd_col}, {21'd0, e_addr_a});
    end
    if (rst_n && bus_b.rd_en === 1'b1) begin
      if (addr_q_b.size() != 0) e_addr_b = {1'b0, addr_q_b.pop_front()};
      else e_addr_b = 11'h7FF;
      check("b_rd_addr", {21'd0, 1'b0, bus_b.rd_row, bus_b.rd_col}, {21'd0, e_addr_b});
    end
    if (bus_a.mosi !== mosi_prev_a) begin
      if (bus_a.s_clk === 1'b1) tviol_a++;
      since_a = 0;
    end else since_a++;
    if (bus_a.s_clk === 1'b1 && sclk_prev_a === 1'b0 && since_a < A_HD) tviol_a++;
    mosi_prev_a = bus_a.mosi;
    sclk_prev_a = bus_a.s_clk;
    if (bus_b.mosi !== mosi_prev_b) begin
      if (bus_b.s_clk === 1'b1) tviol_b++;
      since_b = 0;
    end else since_b++;
    if (bus_b.s_clk === 1'b1 && sclk_prev_b === 1'b0 && since_b < B_HD) tviol_b++;
    mosi_prev_b = bus_b.mosi;
    sclk_prev_b = bus_b.s_clk;
    if (bus_b.done === 1'b1) dcnt_b++;
  end

  always @(posedge bus_b.ss_n) ssrise_b++;

  task automatic push_a(input logic [7:0] b0, input logic [7:0] b1);
    mem_a[0] = b0;
    mem_a[1] = b1;
    exp_q_a.push_back(b0);
    exp_q_a.push_back(b1);
    addr_q_a.push_back(10'd0);
    addr_q_a.push_back(10'd1);
  endtask

  task automatic push_b();
    for (int r = 0; r < MIRROR_ROWS; r++)
      for (int c = 0; c < MIRROR_COLS; c++) begin
        exp_q_b.push_back(8'(r*MIRROR_COLS + c));
        addr_q_b.push_back({4'(r), 6'(c)});
      end
  endtask

  task automatic pulse_start(input bit sel, output int c0);
    @(negedge clk);
    c0 = cyc;
    if (sel) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit, output int cd);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!((sel ? bus_b.done : bus_a.done) === 1'b1) && t < limit);
    cd = cyc;
  endtask

  initial begin
    int c0, cd, t;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_clk", bus_a.s_clk, 1'b0);
    check("rst_ss_n", bus_a.ss_n, 1'b1);
    check("rst_mosi", bus_a.mosi, 1'b0);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_done", bus_a.done, 1'b0);
    check("rst_rd_en", bus_a.rd_en, 1'b0);
    check("rst_rd_addr", {bus_a.rd_row, bus_a.rd_col}, 10'd0);
    check("rst_b_ss_n", bus_b.ss_n, 1'b1);
    rst_n = 1'b1;

    // Two-byte frame: 0x61, 0x62.
    edges_a = 0;
    push_a(8'h61, 8'h62);
    pulse_start(1'b0, c0);
    check("a1_busy", bus_a.busy, 1'b1);
    check("a1_ss_n_low", bus_a.ss_n, 1'b0);
    wait_done(1'b0, 500, cd);
    check("a1_latency", cd - c0, A_LAT);
    check("a1_ss_n_at_done", bus_a.ss_n, 1'b1);
    check("a1_edges", edges_a, 16);
    check("a1_bytes_left", exp_q_a.size(), 0);
    check("a1_reads_left", addr_q_a.size(), 0);

    // Back-to-back frame with a stray start mid-frame and one on the DONE cycle.
    edges_a = 0;
    push_a(8'hA5, 8'h3C);
    pulse_start(1'b0, c0);
    check("a2_busy", bus_a.busy, 1'b1);
    check("a2_ss_n_low", bus_a.ss_n, 1'b0);
    repeat (25) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_done(1'b0, 500, cd);
    check("a2_latency", cd - c0, A_LAT);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    check("a2_done_width", bus_a.done, 1'b0);
    check("a2_busy_after", bus_a.busy, 1'b0);
    repeat (4) @(negedge clk);
    check("a2_start_on_done_ignored", {bus_a.busy, bus_a.ss_n}, 2'b01);
    check("a2_edges", edges_a, 16);
    check("a2_bytes_left", exp_q_a.size(), 0);
    check("a_ss_n_at_edges", ssviol_a, 0);
    check("a_mosi_timing", tviol_a, 0);

    // Default frame aborted by reset during byte 5, bit 3.
    push_b();
    pulse_start(1'b1, c0);
    t = 0;
    while (!(nrx_b == 5 && bits_b == 3) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("b_reach_byte5_bit3", t < 5000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("b_abort_ss_n", bus_b.ss_n, 1'b1);
    check("b_abort_s_clk", bus_b.s_clk, 1'b0);
    check("b_abort_busy", bus_b.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("b_abort_no_done", dcnt_b, 0);

    // Full default frame from (0,0), with a stray start at byte 3.
    exp_q_b.delete();
    addr_q_b.delete();
    bits_b = 0;
    nrx_b = 0;
    edges_b = 0;
    ssrise_b = 0;
    ssviol_b = 0;
    push_b();
    pulse_start(1'b1, c0);
    check("b_busy", bus_b.busy, 1'b1);
    check("b_ss_n_low", bus_b.ss_n, 1'b0);
    t = 0;
    while (nrx_b < 3 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    wait_done(1'b1, B_LAT + 500, cd);
    check("b_latency", cd - c0, B_LAT);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    check("b_done_width", bus_b.done, 1'b0);
    repeat (4) @(negedge clk);
    check("b_start_on_done_ignored", {bus_b.busy, bus_b.ss_n}, 2'b01);
    check("b_edges", edges_b, 8*B_N);
    check("b_bytes_rx", nrx_b, B_N);
    check("b_byte_a5", rx_log_b[165], 8'hA5);
    check("b_row1_col0", rx_log_b[40], 8'h28);
    check("b_bytes_left", exp_q_b.size(), 0);
    check("b_reads_left", addr_q_b.size(), 0);
    check("b_ss_n_at_edges", ssviol_b, 0);
    check("b_ss_n_rises", ssrise_b, 1);
    check("b_mosi_timing", tviol_b, 0);
    check("b_done_count", dcnt_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mirror_spi_master.md
Name: mirror_spi_master

Overview:
SPI master that streams a complete character frame to the mirror display's SPI slave receiver. It is the transmit end of that link.
- Frame order matches the receiver's fill order: col advances fastest, 0..COLS-1, then row advances, 0..ROWS-1.
- Characters are read from a frame-store read port.
- Each byte is sent MSB first, SPI mode 0 (SCLK idles low; receiver samples on rising edge).
- Slave select is held low for the whole frame.

Parameters:
COLS, 40, characters per row
ROWS, 15, rows per frame
HALF_DIV, 4, clk cycles per SCLK half-period (>=1)
GUARD, 4, clk cycles ss_n is low before the first SCLK edge and after the last one

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a frame transfer (ignored while busy)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after ss_n deasserts at frame end
rd_en  out  1  frame-store read strobe, one cycle per character
rd_col  out  6  column of the read
rd_row  out  4  row of the read
rd_data  in  8  character; valid exactly 1 clk after rd_en
s_clk  out  1  SPI clock
ss_n  out  1  slave select, active low
mosi  out  1  serial data

Behaviour:
Reset (async, rst_n=0):
- Outputs: s_clk=0, ss_n=1, mosi=0, busy=0, done=0, rd_en=0, rd_col=0, rd_row=0.
- State goes to IDLE.
- Reset mid-frame aborts immediately. ss_n rises asynchronously and no done is issued.

States:
- IDLE: on start, go to SETUP; col=0, row=0, ss_n<=0, busy<=1.
- SETUP: wait GUARD cycles with s_clk=0, then go to FETCH.
- FETCH: rd_en=1 for one cycle with rd_col=col, rd_row=row; go to LOAD.
- LOAD: shreg<=rd_data, bit count=7, mosi<=rd_data[7]; go to SHIFT.
- SHIFT: each bit is HALF_DIV cycles with s_clk=0 (mosi stable), then HALF_DIV cycles with s_clk=1.
  - On the falling edge after a bit that is not the last, mosi<=next bit, MSB to LSB.
  - After bit 0's high phase, s_clk<=0 and go to NEXT.
- NEXT:
  - If col<COLS-1: col++ and go to FETCH.
  - Else col=0. If row<ROWS-1: row++ and go to FETCH.
  - Else go to HOLD.
  - The FETCH/LOAD/NEXT cycles extend the SCLK low phase between bytes. This is legal because the receiver is edge-clocked.
- HOLD: s_clk=0, ss_n stays 0 for GUARD cycles, then ss_n<=1 and go to DONE.
- DONE: done=1 for one cycle, busy<=0, go to IDLE.

Rules:
- Exactly 8*COLS*ROWS rising s_clk edges per frame (4800 at default); no extra edge at the start or end.
- mosi changes only while s_clk=0, at least HALF_DIV cycles before a rising edge.
- start while busy is ignored. start in the same cycle DONE returns to IDLE is ignored; the next start is accepted from IDLE.
- rd_data is sampled only in LOAD.
- All outputs are registered, no combinational paths from inputs.
- Byte period = 16*HALF_DIV + 3 clk.
- Frame latency, start to done = 1 + 2*GUARD + COLS*ROWS*(16*HALF_DIV+3) + 1 clk, ±1 for the registered state transition, which the bench pins down.

Decomposition:
- Shared package mirror_pkg:
  - constants MIRROR_COLS=40, MIRROR_ROWS=15, COL_W=6, ROW_W=4;
  - state encoding localparams;
  - the same package is shared with the receiver.
- One sub-module, spi_byte_shifter: load, shreg, bit counter, half-period divider, s_clk/mosi generation, and a byte_done pulse.
- The top holds the frame FSM and the col/row counters.

Test Plan:
1. Reset then start with COLS=2, ROWS=1, HALF_DIV=1, rd_data=8'h61 then 8'h62 -> bench SPI slave model captures 0x61, 0x62. rd_en fires twice with (col,row)=(0,0),(1,0). Exactly 16 rising s_clk edges. Then done pulse and busy=0.
2. Default parameters, frame store filled with (row*40+col)[7:0] -> 600 bytes received in order; ss_n low continuously from SETUP to end of HOLD; wrap col 39 -> 0 with row 0 -> 1 verified.
3. Per-bit check, byte 8'hA5 with HALF_DIV=4 -> mosi sequence 1,0,1,0,0,1,0,1. Every mosi transition occurs with s_clk=0, >=4 clk before the rising edge.
4. start pulsed again at byte 3 of a frame -> ignored; byte count and done timing identical to an undisturbed run; start on the DONE cycle also ignored.
5. rst_n low during byte 5, bit 3 -> same cycle ss_n=1, s_clk=0, busy=0; no done. A subsequent start sends the frame from (0,0).
6. Back-to-back frames, start issued the cycle after done -> second frame accepted, ss_n high for >=1 cycle between frames, both frames byte-exact.
